// File: rtl/memory_pkg.sv
// Shared definitions for the memory library history blocks: width helpers,
// mode encodings and the per-stage next-value select.
package memory_pkg;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  // Read-tap width; never zero so a Depth=1 corner still has a port.
  function automatic int calc_aw(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Count width: must hold the value Depth itself.
  function automatic int calc_cw(input int depth);
    return clog2(depth + 1);
  endfunction

  localparam logic MODE_SHIFT     = 1'b0;
  localparam logic MODE_OVERWRITE = 1'b1;

  typedef enum logic [1:0] {
    NXT_HOLD = 2'd0,
    NXT_LOAD = 2'd1,
    NXT_ZERO = 2'd2
  } nxt_e;

endpackage

// File: rtl/register_history_bank_if.sv
// Control/data bundle of the history bank; Q stays a plain port because it is tri-stated.
interface register_history_bank_if
  import memory_pkg::*;
#(
  parameter int NrOfBits = 8,
  parameter int Depth    = 4
);
  localparam int AW = calc_aw(Depth);
  localparam int CW = calc_cw(Depth);

  logic                ClockEnable;
  logic                Tick;
  logic                Clear;
  logic                Mode;
  logic [NrOfBits-1:0] D;
  logic [AW-1:0]       RdSel;
  logic                cs;
  logic [NrOfBits-1:0] Q0;
  logic [CW-1:0]       Count;
  logic                Full;

  modport master (output ClockEnable, Tick, Clear, Mode, D, RdSel, cs,
                  input  Q0, Count, Full);
  modport slave  (input  ClockEnable, Tick, Clear, Mode, D, RdSel, cs,
                  output Q0, Count, Full);
endinterface

// File: rtl/register_history_bank_stage.sv
// One history word: async reset beats async preset, then the muxed next value.
module history_stage
  import memory_pkg::*;
#(
  parameter int NrOfBits    = 8,
  parameter bit ActiveLevel = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                pre,
  input  nxt_e                sel_i,
  input  logic [NrOfBits-1:0] din_i,
  output logic [NrOfBits-1:0] q_o
);
  logic [NrOfBits-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (sel_i)
      NXT_LOAD: q_d = din_i;
      NXT_ZERO: q_d = '0;
      default:  q_d = q_q;
    endcase
  end

  // pre is level-sensitive: any edge while it is high reloads all-ones.
  generate
    if (ActiveLevel) begin : g_pos
      always_ff @(posedge Clock or posedge Reset or posedge pre)
        if (Reset)    q_q <= '0;
        else if (pre) q_q <= '1;
        else          q_q <= q_d;
    end else begin : g_neg
      always_ff @(negedge Clock or posedge Reset or posedge pre)
        if (Reset)    q_q <= '0;
        else if (pre) q_q <= '1;
        else          q_q <= q_d;
    end
  endgenerate

  assign q_o = q_q;
endmodule

// File: rtl/register_history_bank.sv
// Depth-deep shift/overwrite history of NrOfBits words with occupancy count
// and a tap-selected, tri-statable read port.
module register_history_bank
  import memory_pkg::*;
#(
  parameter int NrOfBits    = 8,
  parameter int Depth       = 4,
  parameter bit ActiveLevel = 1'b1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     pre,
  register_history_bank_if.slave   bus,
  output wire  [NrOfBits-1:0]      Q
);
  localparam int AW = calc_aw(Depth);
  localparam int CW = calc_cw(Depth);

  logic                              upd;
  nxt_e [Depth-1:0]                  sel;
  logic [Depth-1:0][NrOfBits-1:0]    din;
  logic [Depth-1:0][NrOfBits-1:0]    ent;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [NrOfBits-1:0]               rd;

  assign upd = bus.ClockEnable & bus.Tick;

  always_comb begin
    din[0] = bus.D;
    for (int i = 1; i < Depth; i++) din[i] = ent[i-1];
  end

  always_comb begin
    for (int i = 0; i < Depth; i++) sel[i] = NXT_HOLD;
    if (upd) begin
      if (bus.Clear)
        for (int i = 0; i < Depth; i++) sel[i] = NXT_ZERO;
      else if (bus.Mode == MODE_SHIFT)
        for (int i = 0; i < Depth; i++) sel[i] = NXT_LOAD;
      else if (bus.Mode == MODE_OVERWRITE)
        sel[0] = NXT_LOAD;
    end
  end

  generate
    for (genvar g = 0; g < Depth; g++) begin : g_stage
      history_stage #(.NrOfBits(NrOfBits), .ActiveLevel(ActiveLevel)) u_stage (
        .Clock (Clock),
        .Reset (Reset),
        .pre   (pre),
        .sel_i (sel[g]),
        .din_i (din[g]),
        .q_o   (ent[g])
      );
    end
  endgenerate

  // Overwrite only bumps an empty bank to 1; otherwise occupancy is unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (upd) begin
      if (bus.Clear)                    cnt_d = '0;
      else if (bus.Mode == MODE_SHIFT) begin
        if (cnt_q != CW'(Depth))        cnt_d = cnt_q + CW'(1);
      end else if (cnt_q == '0)         cnt_d = CW'(1);
    end
  end

  generate
    if (ActiveLevel) begin : g_cnt_pos
      always_ff @(posedge Clock or posedge Reset or posedge pre)
        if (Reset)    cnt_q <= '0;
        else if (pre) cnt_q <= CW'(Depth);
        else          cnt_q <= cnt_d;
    end else begin : g_cnt_neg
      always_ff @(negedge Clock or posedge Reset or posedge pre)
        if (Reset)    cnt_q <= '0;
        else if (pre) cnt_q <= CW'(Depth);
        else          cnt_q <= cnt_d;
    end
  endgenerate

  // Taps past Depth (non-power-of-two banks) match nothing and read zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i < Depth; i++)
      if (bus.RdSel == AW'(i)) rd = ent[i];
  end

  assign Q         = bus.cs ? {NrOfBits{1'bz}} : rd;
  assign bus.Q0    = ent[0];
  assign bus.Count = cnt_q;
  assign bus.Full  = (cnt_q == CW'(Depth));
endmodule

// File: tb/tb_register_history_bank.sv
// Random + directed bench for three bank variants (rising/Depth4, falling/Depth4,
// rising/Depth3) sharing one stimulus stream, checked through a scoreboard.
module tb_register_history_bank;
  import memory_pkg::*;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0, pre = 1'b0;
  logic         ce = 1'b0, tick = 1'b0, clr = 1'b0, mode = 1'b0, cs = 1'b0;
  logic [W-1:0] d = '0;
  logic [1:0]   rdsel = '0;
  wire  [W-1:0] qa, qn, q3;

  register_history_bank_if #(.NrOfBits(W), .Depth(4)) ba ();
  register_history_bank_if #(.NrOfBits(W), .Depth(4)) bn ();
  register_history_bank_if #(.NrOfBits(W), .Depth(3)) b3 ();

  assign ba.ClockEnable = ce; assign ba.Tick = tick; assign ba.Clear = clr; assign ba.Mode = mode;
  assign ba.D = d; assign ba.RdSel = rdsel; assign ba.cs = cs;
  assign bn.ClockEnable = ce; assign bn.Tick = tick; assign bn.Clear = clr; assign bn.Mode = mode;
  assign bn.D = d; assign bn.RdSel = rdsel; assign bn.cs = cs;
  assign b3.ClockEnable = ce; assign b3.Tick = tick; assign b3.Clear = clr; assign b3.Mode = mode;
  assign b3.D = d; assign b3.RdSel = rdsel; assign b3.cs = cs;

  register_history_bank #(.NrOfBits(W), .Depth(4), .ActiveLevel(1'b1)) u_a (
    .Clock(Clock), .Reset(Reset), .pre(pre), .bus(ba), .Q(qa));
  register_history_bank #(.NrOfBits(W), .Depth(4), .ActiveLevel(1'b0)) u_n (
    .Clock(Clock), .Reset(Reset), .pre(pre), .bus(bn), .Q(qn));
  register_history_bank #(.NrOfBits(W), .Depth(3), .ActiveLevel(1'b1)) u_3 (
    .Clock(Clock), .Reset(Reset), .pre(pre), .bus(b3), .Q(q3));

  always #5 Clock = ~Clock;

  // Reference: per variant, entries newest-first plus an occupancy number.
  int           depth_of [3] = '{4, 4, 3};
  logic [W-1:0] me [3][4];
  int           mc [3];

  function automatic void m_async();
    for (int k = 0; k < 3; k++) begin
      if (Reset) begin
        for (int i = 0; i < 4; i++) me[k][i] = '0;
        mc[k] = 0;
      end else if (pre) begin
        for (int i = 0; i < depth_of[k]; i++) me[k][i] = '1;
        mc[k] = depth_of[k];
      end
    end
  endfunction

  function automatic void m_edge(int k);
    if (Reset || pre || !(ce && tick)) return;
    if (clr) begin
      for (int i = 0; i < 4; i++) me[k][i] = '0;
      mc[k] = 0;
    end else if (mode == MODE_SHIFT) begin
      for (int i = depth_of[k] - 1; i > 0; i--) me[k][i] = me[k][i-1];
      me[k][0] = d;
      mc[k] = (mc[k] < depth_of[k]) ? mc[k] + 1 : depth_of[k];
    end else begin
      me[k][0] = d;
      if (mc[k] == 0) mc[k] = 1;
    end
  endfunction

  typedef struct {
    int           k;
    string        tag;
    logic [W-1:0] q;
    bit           qz;
    logic [W-1:0] q0;
    int           cnt;
    bit           full;
  } exp_t;

  exp_t sb[$];
  event ev_chk;
  int   checks = 0, errors = 0;

  task automatic expect_k(int k, string tag);
    exp_t e;
    int   r;
    r      = int'(rdsel);
    e.k    = k;
    e.tag  = tag;
    e.qz   = cs;
    e.q    = (r >= depth_of[k]) ? '0 : me[k][r];
    e.q0   = me[k][0];
    e.cnt  = mc[k];
    e.full = (mc[k] == depth_of[k]);
    sb.push_back(e);
  endtask

  task automatic sample(string tag);
    for (int k = 0; k < 3; k++) expect_k(k, tag);
    ->ev_chk;
    #1;
  endtask

  task automatic sweep(string tag);
    for (int r = 0; r < 4; r++) begin
      rdsel = r[1:0];
      #1;
      sample(tag);
    end
  endtask

  // Inputs apply across one rising and the following falling edge; the
  // enable is dropped afterwards so no unmodelled edge can update anything.
  task automatic step(bit ce_v, bit tick_v, bit clr_v, bit mode_v, logic [W-1:0] d_v, string tag);
    @(negedge Clock); #1;
    ce = ce_v; tick = tick_v; clr = clr_v; mode = mode_v; d = d_v;
    @(posedge Clock); #1;
    m_edge(0); m_edge(2);
    sample({tag, "/rise"});
    @(negedge Clock); #1;
    m_edge(1);
    sample({tag, "/fall"});
    ce = 1'b0; tick = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial forever begin
    @(ev_chk);
    while (sb.size() > 0) begin
      exp_t         e;
      logic [W-1:0] aq, aq0;
      int           ac;
      logic         af;
      bit           ok;
      e = sb.pop_front();
      case (e.k)
        0:       begin aq = qa; aq0 = ba.Q0; ac = int'(ba.Count); af = ba.Full; end
        1:       begin aq = qn; aq0 = bn.Q0; ac = int'(bn.Count); af = bn.Full; end
        default: begin aq = q3; aq0 = b3.Q0; ac = int'(b3.Count); af = b3.Full; end
      endcase
      // A disabled bus floats; 2-state simulation resolves it to zero.
      ok = (e.qz ? (aq === 8'hzz || aq === 8'h00) : (aq === e.q)) &&
           (aq0 === e.q0) && (ac == e.cnt) && (af === e.full);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s dut%0d rdsel=%0d: got Q=%h Q0=%h Count=%0d Full=%b, want Q=%h(z=%0b) Q0=%h Count=%0d Full=%b",
                 e.tag, e.k, rdsel, aq, aq0, ac, af, e.q, e.qz, e.q0, e.cnt, e.full);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      mc[k] = 0;
      for (int i = 0; i < 4; i++) me[k][i] = '0;
    end
    #1 Reset = 1'b1; m_async();
    #2 sweep("reset");
    step(1, 1, 0, MODE_SHIFT, 8'h5A, "edge_in_reset");
    Reset = 1'b0; #1;

    step(1, 1, 0, MODE_SHIFT, 8'h11, "push11");
    step(1, 1, 0, MODE_SHIFT, 8'h22, "push22");
    step(1, 1, 0, MODE_SHIFT, 8'h33, "push33");
    step(1, 1, 0, MODE_SHIFT, 8'h44, "push44");
    step(1, 1, 0, MODE_SHIFT, 8'h55, "push55");
    sweep("shift_taps");

    step(1, 1, 0, MODE_OVERWRITE, 8'h99, "overwrite");
    sweep("overwrite_taps");

    rdsel = 2'd0; cs = 1'b1; #1;
    sample("cs_hiz");
    step(1, 1, 0, MODE_SHIFT, 8'hC3, "cs_push");
    cs = 1'b0; #1;

    step(1, 1, 1, MODE_SHIFT, 8'h77, "clear");
    sweep("clear_taps");

    for (int i = 0; i < 3; i++) step(1, 0, 0, MODE_SHIFT, 8'hAA, "tick_low");
    step(0, 1, 0, MODE_SHIFT, 8'hAB, "ce_low");
    step(1, 1, 0, MODE_SHIFT, 8'hAA, "tick_high");

    step(1, 1, 1, MODE_SHIFT, 8'h00, "clear2");
    step(1, 1, 0, MODE_OVERWRITE, 8'h3C, "overwrite_empty");

    for (int n = 0; n < 60; n++) begin
      rdsel = 2'($urandom_range(0, 3));
      cs    = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), "random");
    end
    cs = 1'b0;

    @(posedge Clock); #2;
    pre = 1'b1; m_async(); #1;
    sweep("preset");
    step(1, 1, 0, MODE_SHIFT, 8'h12, "edge_in_preset");
    Reset = 1'b1; m_async(); #1;
    sweep("reset_over_preset");
    pre = 1'b0; Reset = 1'b0; #1;
    sample("released");
    step(1, 1, 0, MODE_SHIFT, 8'h6D, "push_after_release");

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
